// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and Booth step ops.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic [1:0] booth_op_t;

    localparam booth_op_t BOOTH_NOP = 2'd0;
    localparam booth_op_t BOOTH_ADD = 2'd1;
    localparam booth_op_t BOOTH_SUB = 2'd2;

    // Radix-2 recoding on the current multiplier LSB and the bit shifted out last step.
    function automatic booth_op_t booth_op(input logic q0, input logic q_m1);
        booth_op_t op;
        case ({q0, q_m1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/subtract/pass stage for the Booth accumulator, sized to the A register.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    input  booth_op_t    op,
    output logic [W-1:0] sum
);

    always_comb begin
        sum = a;
        case (op)
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides, one product in flight.
// Define BOOTH_UNSIGNED_EN to add the in_signed port and support unsigned operands.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef BOOTH_UNSIGNED_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam int AW = EW + 1;
    localparam logic [CNT_W-1:0] N_STEPS = CNT_W'(EW);

    state_t           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [EW-1:0]    q_q, q_d;
    logic [AW-1:0]    m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [EW-1:0]    ext_a, ext_b;
    logic [AW-1:0]    sum;
    logic [2*EW-1:0]  prod;

`ifdef BOOTH_UNSIGNED_EN
    // One extra operand bit lets the signed datapath carry unsigned values exactly.
    assign ext_a = {in_signed & in_a[WIDTH-1], in_a};
    assign ext_b = {in_signed & in_b[WIDTH-1], in_b};
`else
    assign ext_a = in_a;
    assign ext_b = in_b;
`endif

    booth_addsub #(.W(AW)) u_addsub (
        .a   (a_q),
        .m   (m_q),
        .op  (booth_op(q_q[0], qm1_q)),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = {ext_a[EW-1], ext_a};
                    q_d     = ext_b;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = N_STEPS;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Arithmetic shift of {A, Q, q_m1} applied directly to the add/sub result.
                a_d   = {sum[AW-1], sum[AW-1:1]};
                q_d   = {sum[0], q_q[EW-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod      = {a_q[EW-1:0], q_q};
    assign out_p     = prod[2*WIDTH-1:0];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed corner cases plus randomized operands and back-pressure.
module tb_booth_mult_seq;

    localparam int W = 16;
`ifdef BOOTH_UNSIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic             busy;

    int               checks;
    int               errors;
    int               cyc;
    int               acc_cyc;
    logic             prev_valid;
    logic             rand_bp;
    logic [2*W-1:0]   exp_q[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef BOOTH_UNSIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as interpreted by mode.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint va, vb, p;
        va = longint'(a);
        vb = longint'(b);
        if (s) begin
            if (a[W-1]) va = va - (longint'(1) << W);
            if (b[W-1]) vb = vb - (longint'(1) << W);
        end
        p = va * vb;
        return p[2*W-1:0];
    endfunction

    // Monitor: latency, busy/in_ready while valid, product against scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid) begin
                if (!prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
                chk("ready_busy_in_done", {62'd0, in_ready, busy}, 64'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_p), 64'hDEAD_0000_0000_0000);
                end else begin
                    chk("out_p", 64'(out_p), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] exp);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
        end else begin
            in_a      = a;
            in_b      = b;
            in_signed = s;
            in_valid  = 1'b1;
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_a     = $urandom();
            in_b     = $urandom();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        acc_cyc   = 0;
        prev_valid = 1'b0;
        rand_bp   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b1;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_p", 64'(out_p), 64'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        issue(16'd3, 16'hFFFB, 1'b1, 32'hFFFF_FFF1);
        issue(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        issue(16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
        issue(16'h1234, 16'h0000, 1'b1, 32'h0000_0000);
        issue(16'h0000, 16'h7FFF, 1'b1, 32'h0000_0000);
        issue(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001);
        drain();

        // Back-pressure: hold the consumer off for 10 clocks in DONE.
        out_ready = 1'b0;
        issue(16'd3, 16'hFFFB, 1'b1, 32'hFFFF_FFF1);
        for (int i = 0; i < 100 && !out_valid; i++) @(posedge clk);
        #1;
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {62'd0, out_valid, in_ready}, 64'd1);
        chk("bp_popped", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of CALC discards the product.
        issue(16'h1111, 16'h2222, 1'b1, 32'h0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(16'd6, 16'd7, 1'b1, 32'd42);
        drain();

`ifdef BOOTH_UNSIGNED_EN
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
        drain();
`endif

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = $urandom();
            b = $urandom();
            if (i % 8 == 0) a = {1'b1, {(W-1){1'b0}}};
            if (i % 8 == 1) b = {W{1'b1}};
`ifdef BOOTH_UNSIGNED_EN
            s = ($urandom_range(0, 1) == 1);
`else
            s = 1'b1;
`endif
            issue(a, b, s, model(a, b, s));
        end
        rand_bp = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
